clint_trap_ctrl: RTL

- Machine-mode trap sequencer. It drives the CSR file's clint write port and consumes its mtvec, mepc, mstatus and interrupt-status outputs.
- On a timer interrupt, ecall or mret at a retiring instruction, it stalls the pipeline and performs the required CSR updates, one write per cycle.
- It then issues a single-cycle PC redirect to the fetch stage.

---
 rtl/clint_trap_ctrl_if.sv | 47 ++++
 rtl/clint_trap_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clint_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clint_trap_ctrl_if
// Brief    : Commit-stage, CSR-file and fetch-redirect bundle for the
//            machine-mode trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface clint_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            inst_valid_i;
    logic [XLEN-1:0] inst_pc_i;
    logic            inst_ecall_i;
    logic            inst_mret_i;
    logic            cpu_csr_wen_i;
    logic [XLEN-1:0] csr_mtvec_i;
    logic [XLEN-1:0] csr_mepc_i;
    logic [XLEN-1:0] csr_mstatus_i;
    logic            global_int_en_i;
    logic            mtime_int_en_i;
    logic            mtime_int_pend_i;
    logic            clint_csr_wen_o;
    logic [11:0]     clint_csr_waddr_o;
    logic [XLEN-1:0] clint_csr_wdata_o;
    logic            clint_stall_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    // Trap sequencer side.
    modport master (
        input  inst_valid_i, inst_pc_i, inst_ecall_i, inst_mret_i,
        input  cpu_csr_wen_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  global_int_en_i, mtime_int_en_i, mtime_int_pend_i,
        output clint_csr_wen_o, clint_csr_waddr_o, clint_csr_wdata_o,
        output clint_stall_o, redirect_valid_o, redirect_pc_o
    );

    // Pipeline / CSR file side.
    modport slave (
        output inst_valid_i, inst_pc_i, inst_ecall_i, inst_mret_i,
        output cpu_csr_wen_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output global_int_en_i, mtime_int_en_i, mtime_int_pend_i,
        input  clint_csr_wen_o, clint_csr_waddr_o, clint_csr_wdata_o,
        input  clint_stall_o, redirect_valid_o, redirect_pc_o
    );
endinterface
`default_nettype wire

// File: rtl/clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clint_trap_ctrl
// Brief    : Machine-mode trap sequencer: writes mepc/mcause/mstatus one per
//            cycle, then issues a single-cycle PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
module clint_trap_ctrl #(
    parameter int XLEN        = 64,
    parameter bit VECTORED_EN = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    clint_trap_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_REDIRECT  = 3'd4
    } state_t;

    localparam logic [1:0]  c_KIND_INT   = 2'd0;
    localparam logic [1:0]  c_KIND_EXC   = 2'd1;
    localparam logic [1:0]  c_KIND_MRET  = 2'd2;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [XLEN-1:0] c_CAUSE_INT   = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    localparam logic [XLEN-1:0] c_CAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'hB};
    localparam logic [XLEN-1:0] c_VEC_OFFSET  = {{(XLEN-5){1'b0}}, 5'h1C};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [1:0]      r_kind;

    logic            w_int_req;
    logic            w_accept;
    logic [1:0]      w_acc_kind;
    logic [XLEN-1:0] w_acc_cause;
    logic            w_vec_mode;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_mstatus_mret;

    logic            w_csr_wen;
    logic [11:0]     w_csr_waddr;
    logic [XLEN-1:0] w_csr_wdata;
    logic            w_stall;
    logic            w_redir_valid;
    logic [XLEN-1:0] w_redir_pc;

    assign w_int_req   = bus.global_int_en_i & bus.mtime_int_en_i & bus.mtime_int_pend_i;
    assign w_tvec_base = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};

    // Vectored dispatch only exists when the build enables it.
    if (VECTORED_EN) begin : g_vectored
        assign w_vec_mode = (bus.csr_mtvec_i[1:0] == 2'b01) && (r_kind == c_KIND_INT);
    end else begin : g_direct
        assign w_vec_mode = 1'b0;
    end

    assign w_trap_target = w_vec_mode ? (w_tvec_base + c_VEC_OFFSET) : w_tvec_base;

    always_comb begin
        w_mstatus_trap        = bus.csr_mstatus_i;
        w_mstatus_trap[7]     = bus.csr_mstatus_i[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;

        w_mstatus_mret        = bus.csr_mstatus_i;
        w_mstatus_mret[3]     = bus.csr_mstatus_i[7];
        w_mstatus_mret[7]     = 1'b1;
        w_mstatus_mret[12:11] = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_epc   <= '0;
            r_cause <= '0;
            r_kind  <= c_KIND_INT;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_epc   <= bus.inst_pc_i;
                r_cause <= w_acc_cause;
                r_kind  <= w_acc_kind;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_acc_kind    = c_KIND_INT;
        w_acc_cause   = '0;
        w_csr_wen     = 1'b0;
        w_csr_waddr   = '0;
        w_csr_wdata   = '0;
        w_stall       = 1'b0;
        w_redir_valid = 1'b0;
        w_redir_pc    = '0;

        case (r_state)
            S_IDLE: begin
                // Stall is raised in the accept cycle itself so the trapped
                // instruction never commits; masked while reset is held.
                if (rst_n && bus.inst_valid_i &&
                    (w_int_req || bus.inst_ecall_i || bus.inst_mret_i)) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    if (w_int_req) begin
                        w_acc_kind  = c_KIND_INT;
                        w_acc_cause = c_CAUSE_INT;
                        w_state_nxt = S_W_MEPC;
                    end else if (bus.inst_ecall_i) begin
                        w_acc_kind  = c_KIND_EXC;
                        w_acc_cause = c_CAUSE_ECALL;
                        w_state_nxt = S_W_MEPC;
                    end else begin
                        w_acc_kind  = c_KIND_MRET;
                        w_state_nxt = S_W_MSTATUS;
                    end
                end
            end
            S_W_MEPC: begin
                w_stall     = 1'b1;
                w_csr_wen   = 1'b1;
                w_csr_waddr = c_ADDR_MEPC;
                w_csr_wdata = r_epc;
                if (!bus.cpu_csr_wen_i) w_state_nxt = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                w_stall     = 1'b1;
                w_csr_wen   = 1'b1;
                w_csr_waddr = c_ADDR_MCAUSE;
                w_csr_wdata = r_cause;
                if (!bus.cpu_csr_wen_i) w_state_nxt = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                w_stall     = 1'b1;
                w_csr_wen   = 1'b1;
                w_csr_waddr = c_ADDR_MSTATUS;
                w_csr_wdata = (r_kind == c_KIND_MRET) ? w_mstatus_mret : w_mstatus_trap;
                if (!bus.cpu_csr_wen_i) w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                w_stall       = 1'b1;
                w_redir_valid = 1'b1;
                w_redir_pc    = (r_kind == c_KIND_MRET) ? bus.csr_mepc_i : w_trap_target;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.clint_csr_wen_o   = w_csr_wen;
    assign bus.clint_csr_waddr_o = w_csr_waddr;
    assign bus.clint_csr_wdata_o = w_csr_wdata;
    assign bus.clint_stall_o     = w_stall;
    assign bus.redirect_valid_o  = w_redir_valid;
    assign bus.redirect_pc_o     = w_redir_pc;

endmodule
`default_nettype wire
